// File: rtl/gen_param_scanner_pkg.sv
// Shared types and elaboration-time helpers for the generated parameter scanner.
package gen_param_scanner_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_REPORT,
        S_DONE
    } state_t;

    // Fixed-point value base + m*step + r + 0.5 with frac_w fractional bits.
    function automatic longint exp_fixed(int m, int r, int base, int step, int frac_w);
        return longint'(base + m * step + r) * (longint'(1) << frac_w)
             + (longint'(1) << (frac_w - 1));
    endfunction

    function automatic bit fits_unsigned(longint v, int w);
        return (v >= 0) && (v < (longint'(1) << w));
    endfunction

endpackage

// File: rtl/gen_param_scanner_leaf.sv
// Leaf holding one elaboration-time constant behind a register.
module param_leaf #(
    parameter int              VAL_W = 16,
    parameter logic [VAL_W-1:0] BAR  = '0
) (
    input  logic             clk,
    input  logic             rst,
    output logic [VAL_W-1:0] bar_o
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bar_o <= '0;
        end else begin
            bar_o <= BAR;
        end
    end

endmodule

// File: rtl/gen_param_scanner.sv
// Scans a generated grid of constant leaves, compares each against its expected
// fixed-point value and reports mismatches over a valid/ready channel.
module gen_param_scanner
    import gen_param_scanner_pkg::*;
#(
    parameter int OUTER_N    = 2,
    parameter int INNER_N    = 2,
    parameter int OUTER_BASE = 10,
    parameter int OUTER_STEP = 10,
    parameter int VAL_W      = 16,
    parameter int FRAC_W     = 8,
    localparam int NCH       = OUTER_N * INNER_N,
    localparam int CH_W      = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int CNT_W     = $clog2(NCH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             inj_en,
    input  logic [CH_W-1:0]  inj_ch,
    output logic             rpt_valid,
    input  logic             rpt_ready,
    output logic [CH_W-1:0]  rpt_ch,
    output logic [VAL_W-1:0] rpt_got,
    output logic [VAL_W-1:0] rpt_exp,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic [CH_W-1:0]  first_err_ch
);

    logic [VAL_W-1:0] leaf_val [NCH];
    logic [VAL_W-1:0] exp_tab  [NCH];

    for (genvar m = 0; m < OUTER_N; m++) begin : g_outer
        for (genvar r = 0; r < INNER_N; r++) begin : g_inner
            localparam longint EXP_L = exp_fixed(m, r, OUTER_BASE, OUTER_STEP, FRAC_W);
            localparam logic [VAL_W-1:0] EXP_V = EXP_L[VAL_W-1:0];

            if (!fits_unsigned(EXP_L, VAL_W)) begin : g_range_err
                $error("expected value of channel %0d does not fit in %0d bits",
                       m * INNER_N + r, VAL_W);
            end

            param_leaf #(
                .VAL_W (VAL_W),
                .BAR   (EXP_V)
            ) u_leaf (
                .clk   (clk),
                .rst   (rst),
                .bar_o (leaf_val[m * INNER_N + r])
            );

            assign exp_tab[m * INNER_N + r] = EXP_V;
        end
    end

    state_t           state;
    logic [CH_W-1:0]  idx;
    logic             inj_hit;
    logic             mismatch;
    logic             last;
    logic [VAL_W-1:0] cur_got;
    logic [VAL_W-1:0] cur_exp;

    // An out-of-range inj_ch can never equal idx, so it injects nothing.
    always_comb begin
        inj_hit  = inj_en && (inj_ch == idx);
        cur_got  = leaf_val[idx] ^ {{(VAL_W-1){1'b0}}, inj_hit};
        cur_exp  = exp_tab[idx];
        mismatch = (cur_got != cur_exp);
        last     = (idx == CH_W'(NCH - 1));
    end

    // NOTE: every register here uses <= so all updates see pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            idx          <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            err_count    <= '0;
            first_err_ch <= '0;
            rpt_valid    <= 1'b0;
            rpt_ch       <= '0;
            rpt_got      <= '0;
            rpt_exp      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state        <= S_SCAN;
                        busy         <= 1'b1;
                        idx          <= '0;
                        err_count    <= '0;
                        pass         <= 1'b0;
                        first_err_ch <= '0;
                    end
                end
                S_SCAN: begin
                    if (mismatch) begin
                        if (err_count != CNT_W'(NCH)) begin
                            err_count <= err_count + CNT_W'(1);
                        end
                        if (err_count == '0) begin
                            first_err_ch <= idx;
                        end
                        rpt_ch    <= idx;
                        rpt_got   <= cur_got;
                        rpt_exp   <= cur_exp;
                        rpt_valid <= 1'b1;
                        state     <= S_REPORT;
                    end else if (last) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        pass  <= (err_count == '0);
                    end else begin
                        idx <= idx + CH_W'(1);
                    end
                end
                S_REPORT: begin
                    if (rpt_ready) begin
                        rpt_valid <= 1'b0;
                        if (last) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            pass  <= (err_count == '0);
                        end else begin
                            idx   <= idx + CH_W'(1);
                            state <= S_SCAN;
                        end
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gen_param_scanner.sv
// Directed and randomized checks of two gen_param_scanner configurations.
module tb_gen_param_scanner;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       rpt_ready;
    logic       inj_en;
    logic [3:0] inj_v;
    logic       sel;

    logic        a_start, a_rpt_valid, a_busy, a_done, a_pass;
    logic [1:0]  a_inj_ch, a_rpt_ch, a_first_err_ch;
    logic [15:0] a_rpt_got, a_rpt_exp;
    logic [2:0]  a_err_count;

    logic        b_start, b_rpt_valid, b_busy, b_done, b_pass;
    logic [3:0]  b_inj_ch, b_rpt_ch, b_first_err_ch;
    logic [15:0] b_rpt_got, b_rpt_exp;
    logic [3:0]  b_err_count;

    assign a_inj_ch = inj_v[1:0];
    assign b_inj_ch = inj_v;

    gen_param_scanner u_dut_a (
        .clk(clk), .rst(rst), .start(a_start), .inj_en(inj_en), .inj_ch(a_inj_ch),
        .rpt_valid(a_rpt_valid), .rpt_ready(rpt_ready), .rpt_ch(a_rpt_ch),
        .rpt_got(a_rpt_got), .rpt_exp(a_rpt_exp), .busy(a_busy), .done(a_done),
        .pass(a_pass), .err_count(a_err_count), .first_err_ch(a_first_err_ch)
    );

    gen_param_scanner #(
        .OUTER_N(3), .INNER_N(4), .OUTER_BASE(0), .OUTER_STEP(5)
    ) u_dut_b (
        .clk(clk), .rst(rst), .start(b_start), .inj_en(inj_en), .inj_ch(b_inj_ch),
        .rpt_valid(b_rpt_valid), .rpt_ready(rpt_ready), .rpt_ch(b_rpt_ch),
        .rpt_got(b_rpt_got), .rpt_exp(b_rpt_exp), .busy(b_busy), .done(b_done),
        .pass(b_pass), .err_count(b_err_count), .first_err_ch(b_first_err_ch)
    );

    // Views of whichever DUT the current scan targets.
    logic        v_valid, v_busy, v_done, v_pass;
    logic [3:0]  v_ch, v_first, v_err;
    logic [15:0] v_got, v_exp;
    assign v_valid = sel ? b_rpt_valid : a_rpt_valid;
    assign v_busy  = sel ? b_busy : a_busy;
    assign v_done  = sel ? b_done : a_done;
    assign v_pass  = sel ? b_pass : a_pass;
    assign v_ch    = sel ? b_rpt_ch : {2'b00, a_rpt_ch};
    assign v_first = sel ? b_first_err_ch : {2'b00, a_first_err_ch};
    assign v_err   = sel ? b_err_count : {1'b0, a_err_count};
    assign v_got   = sel ? b_rpt_got : a_rpt_got;
    assign v_exp   = sel ? b_rpt_exp : a_rpt_exp;

    int vectors    = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Reference: channel c sits at m = c / INNER_N, r = c % INNER_N; value is base+m*step+r+0.5 in Q8.8.
    function automatic logic [15:0] model_exp(input bit s, input int c);
        int inn, base, step, m, r;
        inn  = s ? 4 : 2;
        base = s ? 0 : 10;
        step = s ? 5 : 10;
        m    = c / inn;
        r    = c % inn;
        return 16'((base + m * step + r) * 256 + 128);
    endfunction

    task automatic run_scan(input bit s, input bit ie, input logic [3:0] ic, input int delay,
                            input string tag, output logic [15:0] cap_got,
                            output logic [15:0] cap_exp);
        int lat, nrep, wait_cnt, nch, exp_lat;
        bit hit, in_rpt, seen_done;
        logic [3:0] cap_ch;
        nch       = s ? 12 : 4;
        hit       = ie && (int'(ic) < nch);
        exp_lat   = nch + 1 + (hit ? delay + 1 : 0);
        sel       = s;
        inj_en    = ie;
        inj_v     = ic;
        rpt_ready = 1'b0;
        nrep      = 0;
        wait_cnt  = 0;
        in_rpt    = 1'b0;
        seen_done = 1'b0;
        cap_ch    = '0;
        cap_got   = '0;
        cap_exp   = '0;
        @(negedge clk);
        if (s) b_start = 1'b1; else a_start = 1'b1;
        @(posedge clk);
        lat = 1;
        #1;
        a_start = 1'b0;
        b_start = 1'b0;
        while (lat < 200) begin
            @(negedge clk);
            if (v_done) begin
                seen_done = 1'b1;
                break;
            end
            if (v_valid) begin
                if (!in_rpt) begin
                    in_rpt   = 1'b1;
                    wait_cnt = 0;
                    nrep++;
                    cap_ch  = v_ch;
                    cap_got = v_got;
                    cap_exp = v_exp;
                end else begin
                    check({tag, "_rpt_stable"}, {28'd0, v_ch, v_got, v_exp},
                          {28'd0, cap_ch, cap_got, cap_exp});
                end
                if (wait_cnt >= delay) begin
                    rpt_ready = 1'b1;
                end else begin
                    rpt_ready = 1'b0;
                    wait_cnt++;
                end
            end else begin
                in_rpt    = 1'b0;
                rpt_ready = 1'b0;
            end
            @(posedge clk);
            lat++;
        end
        check({tag, "_done_seen"}, 64'(seen_done), 64'd1);
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_reports"}, 64'(nrep), 64'(hit));
        check({tag, "_pass"}, 64'(v_pass), 64'(!hit));
        check({tag, "_err_count"}, 64'(v_err), 64'(hit));
        check({tag, "_first_err"}, 64'(v_first), hit ? 64'(ic) : 64'd0);
        check({tag, "_busy_in_done"}, 64'(v_busy), 64'd1);
        if (hit) begin
            check({tag, "_rpt_ch"}, 64'(cap_ch), 64'(ic));
            check({tag, "_rpt_exp"}, 64'(cap_exp), 64'(model_exp(s, int'(ic))));
            check({tag, "_rpt_got"}, 64'(cap_got), 64'(model_exp(s, int'(ic)) ^ 16'h0001));
        end
        @(negedge clk);
        check({tag, "_done_pulse"}, {62'd0, v_done, v_busy}, 64'd0);
        rpt_ready = 1'b0;
        inj_en    = 1'b0;
    endtask

    function automatic logic [63:0] a_all_outputs();
        return 64'({a_busy, a_done, a_rpt_valid, a_pass, a_err_count, a_first_err_ch,
                    a_rpt_ch, a_rpt_got, a_rpt_exp});
    endfunction

    logic [15:0] golden [4];
    logic [15:0] got_v, exp_v;
    int          ndone, first_lat;
    bit          saw_rpt;

    initial begin
        golden    = '{16'h0A80, 16'h0B80, 16'h1480, 16'h1580};
        rst       = 1'b1;
        a_start   = 1'b0;
        b_start   = 1'b0;
        rpt_ready = 1'b0;
        inj_en    = 1'b0;
        inj_v     = '0;
        sel       = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs_a", a_all_outputs(), 64'd0);
        check("reset_busy_b", {62'd0, b_busy, b_done}, 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run_scan(1'b0, 1'b0, 4'd0, 0, "a_clean", got_v, exp_v);

        for (int c = 0; c < 4; c++) begin
            run_scan(1'b0, 1'b1, 4'(c), 0, $sformatf("a_inj%0d", c), got_v, exp_v);
            check($sformatf("a_golden_exp%0d", c), 64'(exp_v), 64'(golden[c]));
            check($sformatf("a_golden_got%0d", c), 64'(got_v), 64'(golden[c] ^ 16'h0001));
        end

        run_scan(1'b0, 1'b1, 4'd3, 10, "a_hold", got_v, exp_v);

        // Second start while scanning must be ignored.
        sel   = 1'b0;
        ndone = 0;
        first_lat = 0;
        @(negedge clk);
        a_start = 1'b1;
        @(posedge clk);
        #1 a_start = 1'b0;
        for (int lat = 1; lat <= 20; lat++) begin
            @(negedge clk);
            if (a_done) begin
                ndone++;
                if (ndone == 1) first_lat = lat;
            end
            a_start = (lat == 2);
            @(posedge clk);
        end
        a_start = 1'b0;
        check("dbl_start_pulses", 64'(ndone), 64'd1);
        check("dbl_start_latency", 64'(first_lat), 64'd5);

        // Reset while a report is pending.
        inj_en    = 1'b1;
        inj_v     = 4'd1;
        rpt_ready = 1'b0;
        saw_rpt   = 1'b0;
        @(negedge clk);
        a_start = 1'b1;
        @(posedge clk);
        #1 a_start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (a_rpt_valid) begin
                saw_rpt = 1'b1;
                break;
            end
        end
        check("rst_rpt_reached", 64'(saw_rpt), 64'd1);
        rst = 1'b1;
        #1;
        check("rst_async_zero", a_all_outputs(), 64'd0);
        @(negedge clk);
        check("rst_next_cycle_zero", a_all_outputs(), 64'd0);
        rst    = 1'b0;
        inj_en = 1'b0;
        ndone  = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (a_done || a_busy) ndone++;
        end
        check("rst_no_done_no_busy", 64'(ndone), 64'd0);

        run_scan(1'b1, 1'b0, 4'd0, 0, "b_clean", got_v, exp_v);
        run_scan(1'b1, 1'b1, 4'd11, 1, "b_ch11", got_v, exp_v);
        check("b_ch11_exp_const", 64'(exp_v), 64'h0D80);
        run_scan(1'b1, 1'b1, 4'd13, 0, "b_inj_oob", got_v, exp_v);

        for (int i = 0; i < 12; i++) begin
            bit         s, ie;
            logic [3:0] ic;
            int         d;
            s  = 1'($urandom_range(0, 1));
            ie = 1'($urandom_range(0, 1));
            ic = s ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
            d  = int'($urandom_range(0, 3));
            run_scan(s, ie, ic, d, $sformatf("rnd%0d", i), got_v, exp_v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/gen_param_scanner.md
GEN_PARAM_SCANNER -- requirements
Module: gen_param_scanner

Interface
REQ-001 Parameter OUTER_N, default 2, number of outer generate iterations (m index), range 1..16.
REQ-002 Parameter INNER_N, default 2, number of inner generate iterations (r index), range 1..16.
REQ-003 Parameter OUTER_BASE, default 10, integer value of the first outer step.
REQ-004 Parameter OUTER_STEP, default 10, integer increment per outer index.
REQ-005 Parameter VAL_W, default 16, fixed-point value width.
REQ-006 Parameter FRAC_W, default 8, fractional bits of the value (Q(VAL_W-FRAC_W).FRAC_W).
REQ-007 Derived constants: NCH = OUTER_N*INNER_N; CH_W = max(1, clog2(NCH)); CNT_W = clog2(NCH+1).
REQ-008 Port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-009 Port rst, input, 1, asynchronous active-high reset.
REQ-010 Ports: start in 1, single-cycle scan request.
REQ-011 Ports: inj_en in 1 and inj_ch in CH_W, fault injection; when inj_en=1, channel inj_ch reports its value with bit 0 inverted.
REQ-012 Ports: rpt_valid out 1, rpt_ready in 1, rpt_ch out CH_W, rpt_got out VAL_W, rpt_exp out VAL_W; mismatch report channel.
REQ-013 Ports: busy out 1, done out 1 (pulse), pass out 1, err_count out CNT_W, first_err_ch out CH_W.

Function
REQ-014 Channel c = m*INNER_N + r, m in 0..OUTER_N-1, r in 0..INNER_N-1.
REQ-015 Expected value of channel c = (OUTER_BASE + m*OUTER_STEP + r) * 2^FRAC_W + 2^(FRAC_W-1), i.e. base + r + 0.5; computed at elaboration; out-of-range values (overflow of VAL_W) are an elaboration error.
REQ-016 Each channel instantiates one leaf; the leaf receives the expected value as parameter and drives a registered output equal to it (0 during reset).
REQ-017 FSM states: IDLE, SCAN, REPORT, DONE; reset state IDLE.
REQ-018 IDLE: start=1 -> SCAN, idx=0, err_count=0, pass=0, first_err_ch=0; else stay.
REQ-019 SCAN: one channel compared per cycle (leaf value after injection vs expected); match and idx<NCH-1 -> idx+1; match and idx=NCH-1 -> DONE.
REQ-020 SCAN mismatch: err_count+1 (saturating at NCH), first_err_ch captured only on the first mismatch, latch rpt_ch/rpt_got/rpt_exp, go to REPORT.
REQ-021 REPORT: rpt_valid=1; rpt_* stable until rpt_valid&&rpt_ready; on handshake -> SCAN with idx+1, or DONE if idx=NCH-1.
REQ-022 DONE: done=1 for exactly one cycle, pass=(err_count==0) registered and held until next start; -> IDLE.
REQ-023 busy=1 in SCAN, REPORT, DONE; start while busy is ignored.
REQ-024 Latency, no mismatches: start at edge k -> channel i compared in cycle after edge k+1+i -> done high in cycle after edge k+1+NCH.
REQ-025 inj_en/inj_ch are sampled combinationally at each compare; inj_ch >= NCH injects nothing.

Reset
REQ-026 rst asserted at any time returns the FSM to IDLE immediately; busy, done, rpt_valid, pass, err_count, first_err_ch, idx, rpt_* all 0.
REQ-027 A scan interrupted by rst is abandoned; no done pulse; a new start is required.

Structure
REQ-028 Package gen_param_scanner_pkg holds the state enum and the function computing the expected fixed-point value from (m, r, parameters).
REQ-029 One sub-module, param_leaf, parameter VAL_W and BAR (VAL_W bits), ports clk, rst, bar_o.

Verification
REQ-030 Defaults, start, no injection -> values 0x0A80, 0x0B80, 0x1480, 0x1580 compared; done exactly 5 cycles after start edge; pass=1; err_count=0; rpt_valid never 1.
REQ-031 inj_en=1, inj_ch=2, rpt_ready=1 -> one report rpt_ch=2, rpt_got=0x1481, rpt_exp=0x1480; err_count=1, first_err_ch=2, pass=0.
REQ-032 inj_ch=3, rpt_ready held 0 for 10 cycles -> rpt_valid and rpt_* stable for all 10 cycles; done only after ready rises.
REQ-033 Second start pulse during SCAN -> ignored; exactly one done pulse per accepted start.
REQ-034 rst asserted while in REPORT -> next cycle all outputs 0, state IDLE, no done pulse.
REQ-035 OUTER_N=3, INNER_N=4, OUTER_BASE=0, OUTER_STEP=5 -> 12 channels, channel 11 expects 13.5 = 0x0D80; pass=1 after 13 cycles.
